// File: rtl/bnn_conv_engine.sv
// First binary conv stage: 3x3 valid-mode XNOR-popcount over a 28x28 image,
// eight kernels, one thresholded activation bit per valid/ready beat.
module bnn_conv_engine #(
   parameter int THRESH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [27:0][27:0]      pixels,
   input  logic [7:0][2:0][2:0]   weights,
   input  logic                   load_done,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic                   out_bit,
   output logic [2:0]             out_filter,
   output logic [4:0]             out_row,
   output logic [4:0]             out_col,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] f_q;
   logic [4:0] r_q;
   logic [4:0] c_q;
   logic       scan_end_q;
   logic [3:0] pop;
   logic       accept;
   logic       load;
   logic       at_end;
   logic       act;

   assign accept = out_valid & out_ready;
   assign at_end = (f_q == 3'd7) && (r_q == 5'd25) && (c_q == 5'd25);
   assign load   = (state_q == RUN) && !scan_end_q && (!out_valid || out_ready);

   always_comb begin
      pop = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            pop = pop + {3'b000,
               ~(pixels[r_q + 5'(i)][c_q + 5'(j)] ^ weights[f_q][2'(i)][2'(j)])};
         end
      end
   end

   assign act = (pop >= 4'(THRESH));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (load_done) state_d = RUN;
         RUN:  if (accept && out_last) state_d = DONE;
         DONE: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Scan counters move only when a position is committed to the output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_q        <= '0;
         r_q        <= '0;
         c_q        <= '0;
         scan_end_q <= 1'b0;
      end else if (load) begin
         if (at_end) scan_end_q <= 1'b1;
         if (c_q == 5'd25) begin
            c_q <= '0;
            if (r_q == 5'd25) begin
               r_q <= '0;
               f_q <= f_q + 3'd1;
            end else begin
               r_q <= r_q + 5'd1;
            end
         end else begin
            c_q <= c_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_bit    <= 1'b0;
         out_filter <= '0;
         out_row    <= '0;
         out_col    <= '0;
         out_last   <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_bit    <= act;
         out_filter <= f_q;
         out_row    <= r_q;
         out_col    <= c_q;
         out_last   <= at_end;
      end else if (accept) begin
         out_valid  <= 1'b0;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine: two instances (THRESH 5 and 9) share
// stimulus; beats are captured and compared against hand-derived patterns.
module tb_bnn_conv_engine;

   localparam int NB = 5408;

   logic clk = 1'b0;
   logic reset;
   logic load_done;
   logic out_ready;
   logic [27:0][27:0]    pixels;
   logic [7:0][2:0][2:0] weights;

   logic v5, b5, l5, busy5, done5;
   logic [2:0] f5;
   logic [4:0] r5, c5;
   logic v9, b9, l9, busy9, done9;
   logic [2:0] f9;
   logic [4:0] r9, c9;

   int tests = 0;
   int fails = 0;

   bit         cap_b5 [NB];
   bit         cap_b9 [NB];
   bit         cap_last [NB];
   logic [2:0] cap_f [NB];
   logic [4:0] cap_r [NB];
   logic [4:0] cap_c [NB];
   int n_acc;
   bit timed_out;
   int stall_errs;
   int lock_errs;
   bit done_pre, done_post, busy_post, valid_post;

   always #5 clk = ~clk;

   bnn_conv_engine #(.THRESH(5)) dut5 (
      .clk(clk), .reset(reset), .pixels(pixels), .weights(weights),
      .load_done(load_done), .out_ready(out_ready),
      .out_valid(v5), .out_bit(b5), .out_filter(f5), .out_row(r5),
      .out_col(c5), .out_last(l5), .busy(busy5), .done(done5)
   );

   bnn_conv_engine #(.THRESH(9)) dut9 (
      .clk(clk), .reset(reset), .pixels(pixels), .weights(weights),
      .load_done(load_done), .out_ready(out_ready),
      .out_valid(v9), .out_bit(b9), .out_filter(f9), .out_row(r9),
      .out_col(c9), .out_last(l9), .busy(busy9), .done(done9)
   );

   function automatic int exp_f(int i);
      return i / 676;
   endfunction

   function automatic int exp_r(int i);
      return (i % 676) / 26;
   endfunction

   function automatic int exp_c(int i);
      return i % 26;
   endfunction

   function automatic int order_errs();
      int e = 0;
      for (int i = 0; i < NB; i++)
         if (int'(cap_f[i]) != exp_f(i) || int'(cap_r[i]) != exp_r(i)
             || int'(cap_c[i]) != exp_c(i)) e++;
      return e;
   endfunction

   function automatic int last_errs();
      int e = 0;
      for (int i = 0; i < NB; i++)
         if (cap_last[i] != (i == NB - 1)) e++;
      return e;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      load_done = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_scan(input bit rnd, input int stop_at);
      int stall_left = 0;
      bit stalled = 0;
      logic [14:0] held = '0;
      n_acc = 0; timed_out = 1; stall_errs = 0; lock_errs = 0;
      done_pre = 0; done_post = 0; busy_post = 1; valid_post = 1;
      for (int i = 0; i < NB; i++) begin
         cap_b5[i] = 0; cap_b9[i] = 0; cap_last[i] = 0;
         cap_f[i] = '0; cap_r[i] = '0; cap_c[i] = '0;
      end
      load_done = 1'b1;
      for (int cyc = 0; cyc < 40000; cyc++) begin
         @(negedge clk);
         if (v9 !== v5) lock_errs++;
         if (n_acc >= 50) load_done = 1'b0;
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (v5 !== 1'b1 || {b5, f5, r5, c5, l5} !== held) stall_errs++;
         end else if (rnd && !stalled && n_acc == 100 && v5) begin
            stalled = 1;
            stall_left = 9;
            out_ready = 1'b0;
            held = {b5, f5, r5, c5, l5};
         end else begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (v5 && out_ready && n_acc < NB) begin
            cap_b5[n_acc] = b5;
            cap_b9[n_acc] = b9;
            cap_last[n_acc] = l5;
            cap_f[n_acc] = f5;
            cap_r[n_acc] = r5;
            cap_c[n_acc] = c5;
            done_pre = done5;
            n_acc++;
         end
         if (n_acc == stop_at) begin
            timed_out = 0;
            break;
         end
      end
      if (!timed_out && stop_at == NB) begin
         @(negedge clk);
         done_post = done5;
         busy_post = busy5;
         valid_post = v5;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_done = 1'b0;
      out_ready = 1'b0;
      pixels = '1;
      weights = '1;
      #1;
      tests++;
      if ({v5, b5, f5, r5, c5, l5, busy5, done5} !== 18'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h want 0",
                  {v5, b5, f5, r5, c5, l5, busy5, done5});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy5 !== 1'b0 || v5 !== 1'b0) begin
         fails++;
         $display("FAIL idle_hold: busy %b valid %b want 0 0", busy5, v5);
      end
      load_done = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (busy5 !== 1'b1 || v5 !== 1'b0) begin
         fails++;
         $display("FAIL e0_timing: busy %b valid %b want 1 0", busy5, v5);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({v5, f5, r5, c5, l5} !== {1'b1, 14'd0}) begin
         fails++;
         $display("FAIL e1_first_beat: got %h want %h",
                  {v5, f5, r5, c5, l5}, {1'b1, 14'd0});
      end
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({v5, f5, r5, c5} !== {1'b1, 13'd0}) begin
         fails++;
         $display("FAIL hold_no_ready: got %h want %h",
                  {v5, f5, r5, c5}, {1'b1, 13'd0});
      end
   endtask

   task automatic test_all_ones();
      int e = 0;
      do_reset();
      pixels = '1;
      weights = '1;
      run_scan(0, NB);
      tests++;
      if (timed_out) begin
         fails++;
         $display("FAIL ones_timeout: got %0d beats want %0d", n_acc, NB);
      end
      tests++;
      if (order_errs() != 0) begin
         fails++;
         $display("FAIL ones_order: got %0d bad positions want 0", order_errs());
      end
      for (int i = 0; i < NB; i++) if (cap_b5[i] !== 1'b1) e++;
      tests++;
      if (e != 0) begin
         fails++;
         $display("FAIL ones_bits: got %0d zero bits want 0", e);
      end
      tests++;
      if (last_errs() != 0) begin
         fails++;
         $display("FAIL ones_last: got %0d bad last flags want 0", last_errs());
      end
      tests++;
      if ({done_pre, done_post, busy_post, valid_post} !== 4'b0100) begin
         fails++;
         $display("FAIL ones_done: got pre/post/busy/valid %b want 0100",
                  {done_pre, done_post, busy_post, valid_post});
      end
   endtask

   task automatic test_filter_select();
      int e = 0;
      do_reset();
      pixels = '0;
      weights = '1;
      weights[1] = '0;
      run_scan(0, NB);
      for (int i = 0; i < NB; i++)
         if (cap_b5[i] !== (exp_f(i) == 1)) e++;
      tests++;
      if (timed_out || e != 0) begin
         fails++;
         $display("FAIL filter_select: got %0d bad bits (timeout %b) want 0",
                  e, timed_out);
      end
   endtask

   task automatic test_checker();
      int e5 = 0;
      int e9 = 0;
      do_reset();
      weights = '0;
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++)
            pixels[r][c] = 1'((r + c) % 2);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            weights[0][i][j] = 1'((i + j) % 2);
      run_scan(0, NB);
      for (int i = 0; i < 676; i++) begin
         if (cap_b5[i] !== ((exp_r(i) + exp_c(i)) % 2 == 0)) e5++;
         if (cap_b9[i] !== ((exp_r(i) + exp_c(i)) % 2 == 0)) e9++;
      end
      tests++;
      if (timed_out || e5 != 0) begin
         fails++;
         $display("FAIL checker_t5: got %0d bad bits (timeout %b) want 0",
                  e5, timed_out);
      end
      tests++;
      if (e9 != 0) begin
         fails++;
         $display("FAIL checker_t9: got %0d bad bits want 0", e9);
      end
   endtask

   task automatic test_thresh9();
      int e9 = 0;
      int e5 = 0;
      do_reset();
      pixels = '1;
      weights = '1;
      weights[3][1][1] = 1'b0;
      run_scan(0, NB);
      for (int i = 0; i < NB; i++) begin
         if (cap_b9[i] !== (exp_f(i) != 3)) e9++;
         if (cap_b5[i] !== 1'b1) e5++;
      end
      tests++;
      if (timed_out || e9 != 0) begin
         fails++;
         $display("FAIL thresh9_bits: got %0d bad bits (timeout %b) want 0",
                  e9, timed_out);
      end
      tests++;
      if (e5 != 0) begin
         fails++;
         $display("FAIL thresh5_pop8: got %0d bad bits want 0", e5);
      end
      tests++;
      if (lock_errs != 0) begin
         fails++;
         $display("FAIL thresh_lockstep: got %0d valid diffs want 0", lock_errs);
      end
   endtask

   task automatic test_backpressure();
      int e = 0;
      do_reset();
      pixels = '0;
      weights = '1;
      weights[1] = '0;
      run_scan(1, NB);
      tests++;
      if (timed_out) begin
         fails++;
         $display("FAIL bp_timeout: got %0d beats want %0d", n_acc, NB);
      end
      tests++;
      if (stall_errs != 0) begin
         fails++;
         $display("FAIL bp_stall_hold: got %0d changed cycles want 0", stall_errs);
      end
      tests++;
      if (order_errs() != 0 || last_errs() != 0) begin
         fails++;
         $display("FAIL bp_order: got %0d/%0d bad order/last want 0/0",
                  order_errs(), last_errs());
      end
      for (int i = 0; i < NB; i++)
         if (cap_b5[i] !== (exp_f(i) == 1)) e++;
      tests++;
      if (e != 0) begin
         fails++;
         $display("FAIL bp_bits: got %0d bad bits want 0", e);
      end
      tests++;
      if ({done_post, valid_post} !== 2'b10) begin
         fails++;
         $display("FAIL bp_done: got done/valid %b want 10", {done_post, valid_post});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pixels = '1;
      weights = '1;
      run_scan(0, 1000);
      tests++;
      if (timed_out) begin
         fails++;
         $display("FAIL mid_timeout: got %0d beats want 1000", n_acc);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if ({v5, b5, f5, r5, c5, l5, busy5, done5} !== 18'd0) begin
         fails++;
         $display("FAIL mid_reset_clear: got %h want 0",
                  {v5, b5, f5, r5, c5, l5, busy5, done5});
      end
      @(negedge clk);
      load_done = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (busy5 !== 1'b0 || v5 !== 1'b0 || done5 !== 1'b0) begin
         fails++;
         $display("FAIL mid_idle: busy %b valid %b done %b want 0 0 0",
                  busy5, v5, done5);
      end
      run_scan(0, NB);
      tests++;
      if (timed_out || order_errs() != 0 || last_errs() != 0) begin
         fails++;
         $display("FAIL mid_restart: got beats %0d order %0d last %0d want %0d 0 0",
                  n_acc, order_errs(), last_errs(), NB);
      end
      tests++;
      if (done_post !== 1'b1) begin
         fails++;
         $display("FAIL mid_done: got %b want 1", done_post);
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_filter_select();
      test_checker();
      test_thresh9();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
